// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader: request kinds,
// MIPS opcode and funct values, loader FSM states and word-packing helpers.
package instr_encoder_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } load_state_e;

    // Symbolic request kinds; codes 10-15 are illegal.
    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_AND  = 4'd2;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_ADDI = 4'd4;
    localparam logic [3:0] K_ORI  = 4'd5;
    localparam logic [3:0] K_BEQ  = 4'd6;
    localparam logic [3:0] K_J    = 4'd7;
    localparam logic [3:0] K_LW   = 4'd8;
    localparam logic [3:0] K_SW   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    function automatic logic [31:0] pack_rtype(input logic [4:0] rs,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd,
                                               input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] pack_itype(input logic [5:0]  op,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: turns a request kind plus its register/immediate/
// target fields into a 32-bit MIPS word and flags kinds with no encoding.
// Ports:
//   kind    in  4   request kind (0-9 legal)
//   rs/rt/rd in 5   register fields
//   imm     in  16  immediate / branch offset, passed through unmodified
//   target  in  26  jump target (J only)
//   word    out 32  encoded instruction (0 when illegal)
//   illegal out 1   kind has no encoding
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            K_ADD:   word = pack_rtype(rs, rt, rd, FN_ADD);
            K_SUB:   word = pack_rtype(rs, rt, rd, FN_SUB);
            K_AND:   word = pack_rtype(rs, rt, rd, FN_AND);
            K_OR:    word = pack_rtype(rs, rt, rd, FN_OR);
            K_ADDI:  word = pack_itype(OP_ADDI, rs, rt, imm);
            K_ORI:   word = pack_itype(OP_ORI, rs, rt, imm);
            K_BEQ:   word = pack_itype(OP_BEQ, rs, rt, imm);
            K_LW:    word = pack_itype(OP_LW, rs, rt, imm);
            K_SW:    word = pack_itype(OP_SW, rs, rt, imm);
            K_J:     word = {OP_J, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic instruction requests on a valid/ready
// stream, encodes each into a MIPS word and writes it to consecutive
// instruction-memory addresses starting at base_addr.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base_addr    begin a load (ignored while loading)
//   in_valid/in_ready   request handshake
//   in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last  request fields
//   imem_we/addr/wdata  instruction-memory write port (one cycle after accept)
//   busy, done, err     status levels
//   count               words written in the current load (saturates at IMEM_DEPTH)
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(IMEM_DEPTH);

    load_state_e       state_q;
    load_state_e       state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;

    logic [31:0]       word_p0;
    logic              illegal_p0;
    logic              accept_p0;
    logic              write_p0;
    logic              start_ok;
    logic              fills_mem;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [31:0]       wdata_p1;

    instr_field_packer u_packer (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (word_p0),
        .illegal (illegal_p0)
    );

    // Stage p0: handshake and encode
    assign in_ready  = (state_q == ST_LOAD) && (count_q < DEPTH_CNT);
    assign accept_p0 = in_valid && in_ready;
    assign write_p0  = accept_p0 && !illegal_p0;
    assign start_ok  = start && (state_q != ST_LOAD);
    // This accepted beat is the one that fills the whole memory.
    assign fills_mem = (count_q == DEPTH_CNT - 1'b1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (accept_p0) begin
                    if (illegal_p0) begin
                        state_d = ST_ERR;
                    end else if (in_last) begin
                        state_d = ST_DONE;
                    end else if (fills_mem) begin
                        state_d = ST_ERR;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                ptr_q   <= base_addr;
                count_q <= '0;
            end else if (write_p0) begin
                // ptr is exactly ADDR_W bits, so it wraps modulo IMEM_DEPTH.
                ptr_q <= ptr_q + 1'b1;
                if (count_q != DEPTH_CNT) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    // Stage p1: registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= write_p0;
            if (write_p0) begin
                addr_p1  <= ptr_q;
                wdata_p1 <= word_p0;
            end
        end
    end

    assign imem_we    = vld_p1;
    assign imem_addr  = addr_p1;
    assign imem_wdata = wdata_p1;
    assign busy       = (state_q == ST_LOAD);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_kind = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, err;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model of the load in progress
    int exp_ptr = 0;
    int exp_cnt = 0;

    instr_encoder_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Encoding from the MIPS field layout using plain arithmetic.
    function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                             input int rd, input int imm, input int tgt);
        logic [31:0] r_base, i_base, op, fn;
        r_base = rs * 32'h0020_0000 + rt * 32'h0001_0000 + rd * 32'h0000_0800;
        i_base = rs * 32'h0020_0000 + rt * 32'h0001_0000 + imm;
        op = 0; fn = 0;
        case (kind)
            0: fn = 32'h20;
            1: fn = 32'h22;
            2: fn = 32'h24;
            3: fn = 32'h25;
            4: op = 32'h08;
            5: op = 32'h0D;
            6: op = 32'h04;
            8: op = 32'h23;
            9: op = 32'h2B;
            default: ;
        endcase
        if (kind <= 3) return r_base + fn;
        if (kind == 7) return 32'h0800_0000 + tgt;
        return op * 32'h0400_0000 + i_base;
    endfunction

    task automatic do_start(input int b);
        start = 1'b1;
        base_addr = AW'(b);
        @(posedge clk); #1;
        start = 1'b0;
        exp_ptr = b;
        exp_cnt = 0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
        chk("start_count", count, 0);
    endtask

    // Present one request (after optional idle gap), wait for acceptance and
    // check the write that must appear in the following cycle.
    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input bit last, input int gap);
        bit acc;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk("gap_we", imem_we, 0);
        end
        in_kind = 4'(kind); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 20 && !acc; c++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        if (kind < 10) begin
            chk("wr_we", imem_we, 1);
            chk("wr_addr", imem_addr, exp_ptr);
            chk("wr_data", imem_wdata, ref_word(kind, rs, rt, rd, imm, tgt));
            exp_ptr = (exp_ptr + 1) % DEPTH;
            if (exp_cnt < DEPTH) exp_cnt++;
            if (last) chk("last_done", done, 1);
        end else begin
            chk("illegal_we", imem_we, 0);
            chk("illegal_err", err, 1);
        end
        chk("count", count, exp_cnt);
    endtask

    initial begin
        int kind, n;
        bit stopped;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", in_ready, 0);

        // Single ADD with last
        do_start(0);
        send(0, 1, 2, 3, 0, 0, 1, 0);
        chk("add_word", imem_wdata, 32'h0022_1820);
        chk("add_busy", busy, 0);
        @(posedge clk); #1;
        chk("add_after_we", imem_we, 0);
        chk("add_after_done", done, 1);
        chk("add_after_ready", in_ready, 0);

        // Back-to-back ADDI, LW, BEQ; a start mid-load must be ignored
        do_start(0);
        send(4, 0, 5, 0, 16'hFFFF, 0, 0, 0);
        chk("addi_word", imem_wdata, 32'h2005_FFFF);
        start = 1'b1; base_addr = 8'd77;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ign_we", imem_we, 0);
        chk("start_ign_busy", busy, 1);
        send(8, 29, 8, 0, 4, 0, 0, 0);
        chk("lw_word", imem_wdata, 32'h8FA8_0004);
        send(6, 1, 2, 0, 16'hFFFE, 0, 1, 0);
        chk("beq_word", imem_wdata, 32'h1022_FFFE);
        chk("beq_addr", imem_addr, 2);
        chk("b2b_count", count, 3);

        // J at the top address, then SW wraps to address 0
        do_start(255);
        send(7, 0, 0, 0, 0, 26'h10, 0, 0);
        chk("j_word", imem_wdata, 32'h0800_0010);
        chk("j_addr", imem_addr, 255);
        send(9, 3, 4, 0, 16'h0008, 0, 1, 0);
        chk("sw_wrap_addr", imem_addr, 0);

        // Illegal kind mid-stream
        do_start(40);
        send(1, 7, 8, 9, 0, 0, 0, 0);
        send(12, 1, 1, 1, 0, 0, 0, 0);
        chk("illegal_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("illegal_hold_err", err, 1);
        chk("illegal_hold_we", imem_we, 0);
        do_start(41);
        send(3, 2, 2, 2, 0, 0, 1, 1);

        // Overflow: fill every address without a last
        do_start(5);
        for (int i = 0; i < DEPTH; i++) begin
            send($urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 1023), 0, 0);
        end
        chk("ovf_err", err, 1);
        chk("ovf_ready", in_ready, 0);
        chk("ovf_count", count, DEPTH);
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("ovf_extra_we", imem_we, 0);
        end
        in_valid = 1'b0;

        // Randomized programs
        for (int t = 0; t < 8; t++) begin
            do_start($urandom_range(0, DEPTH - 1));
            n = $urandom_range(1, 12);
            stopped = 1'b0;
            for (int i = 0; i < n && !stopped; i++) begin
                kind = ($urandom_range(0, 14) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                send(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 65535), $urandom_range(0, 67108863), i == n - 1,
                     $urandom_range(0, 2));
                if (kind >= 10) stopped = 1'b1;
            end
            chk("rand_done", done, !stopped);
            chk("rand_err", err, stopped);
            chk("rand_ready", in_ready, 0);
        end

        // Reset while a write is pending and requests keep streaming
        do_start(10);
        in_kind = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_we", imem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", imem_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_count", count, 0);
        chk("midrst_addr", imem_addr, 0);
        chk("midrst_wdata", imem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("postrst_ready", in_ready, 0);
            chk("postrst_we", imem_we, 0);
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
